mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have port: inst_rdy  input  1  inst SRAM returns a valid instruction this cycle.
REQ-004 The block SHALL have port: data_rdy  input  1  data SRAM access completes this cycle.
REQ-005 The block SHALL have port: dec_load  input  1  decoded instruction is ld.w.
REQ-006 The block SHALL have port: dec_store  input  1  decoded instruction is st.w.
REQ-007 The block SHALL have port: dec_gr_we  input  1  decoded instruction writes the regfile.
REQ-008 The block SHALL have port: inst_req  output  1  fetch request to inst SRAM.
REQ-009 The block SHALL have port: ir_we  output  1  latch instruction register.
REQ-010 The block SHALL have port: data_req  output  1  data SRAM access request.
REQ-011 The block SHALL have port: data_sram_we  output  1  data SRAM write strobe.
REQ-012 The block SHALL have port: rf_we  output  1  regfile write enable.
REQ-013 The block SHALL have port: pc_we  output  1  PC update; doubles as the retire pulse.
REQ-014 The block SHALL have port: state  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, IDLE=7.
REQ-015 The block SHALL have port: cycle_cnt  output  32  cycle counter (see Configuration).
REQ-016 The block SHALL have port: retire_cnt  output  32  retired-instruction counter (see Configuration).

Function
REQ-017 All outputs except the counters SHALL be combinational decodes of the state register and the current inputs (Moore/Mealy as stated per signal); there is no other output register.
REQ-018 Upstream SHALL hold dec_load, dec_store and dec_gr_we stable from ID through the last cycle of each instruction; the block SHALL sample them combinationally in EXE, MEM and WB.
REQ-019 IDLE SHALL go to IF unconditionally on the next edge.
REQ-020 IF SHALL assert inst_req; IF SHALL stay in IF while inst_rdy=0; with inst_rdy=1 it SHALL assert ir_we and go to ID.
REQ-021 ID SHALL go to EXE unconditionally.
REQ-022 EXE SHALL go to MEM if dec_load or dec_store; else to WB if dec_gr_we; else to IF, asserting pc_we in that EXE cycle.
REQ-023 MEM SHALL assert data_req every cycle, and SHALL assert data_sram_we every cycle when dec_store=1 and dec_load=0.
REQ-024 MEM SHALL stay in MEM while data_rdy=0; with data_rdy=1 it SHALL go to WB on a load, or to IF with pc_we asserted on a store.
REQ-025 dec_load and dec_store both high SHALL be treated as a load: no write strobe, exit MEM to WB.
REQ-026 WB SHALL assert rf_we iff dec_gr_we=1, SHALL assert pc_we, and SHALL go to IF.
REQ-027 pc_we SHALL be high for exactly one cycle per instruction.
REQ-028 Latency SHALL be: ALU op 4 cycles; branch or jump without write 3 cycles; store 4 cycles; load 5 cycles; each with inst_rdy/data_rdy high on the first request cycle. Every stalled request cycle SHALL add one cycle.
REQ-029 The encodings 5 and 6 are illegal; the block SHALL go to IDLE on the next edge and SHALL assert no strobes while in either.

Reset
REQ-030 Asserting reset SHALL force state to IDLE immediately, independent of clk, including mid-instruction or mid-stall; any pending request SHALL be abandoned.
REQ-031 During reset and in IDLE, inst_req, ir_we, data_req, data_sram_we, rf_we and pc_we SHALL be 0, and cycle_cnt and retire_cnt SHALL be 0.
REQ-032 The first IF SHALL occur in the second cycle after reset deassertion.

Configuration
REQ-033 With macro MC_CTRL_PERF_EN defined, cycle_cnt SHALL increment every cycle outside reset and retire_cnt SHALL increment on every pc_we; both SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 Without MC_CTRL_PERF_EN, cycle_cnt and retire_cnt SHALL be constant 0, no counter flops SHALL exist, and the ports SHALL remain present.

Verification
REQ-035 The bench SHALL cover: reset release, inst_rdy=1, dec_gr_we=1, no load or store -> state sequence 7,0,1,2,4,0; rf_we and pc_we high only in the WB cycle.
REQ-036 The bench SHALL cover: a load with data_rdy low for 2 MEM cycles -> 7 cycles IF to IF, data_req high 3 cycles, data_sram_we never high, rf_we=1 in WB.
REQ-037 The bench SHALL cover: a store with data_rdy=1 -> IF,ID,EXE,MEM then IF; data_sram_we high 1 cycle; pc_we in MEM; rf_we never high.
REQ-038 The bench SHALL cover: a branch (all dec_* 0) -> 3-cycle instruction; pc_we in EXE.
REQ-039 The bench SHALL cover: reset asserted mid-MEM stall -> state=7 and all strobes 0 without waiting for a clk edge; normal fetch resumes after release.
REQ-040 The bench SHALL cover: with MC_CTRL_PERF_EN defined, 10 ALU instructions -> retire_cnt=10 and cycle_cnt=41 at the eleventh fetch; without the macro, both read 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle CPU control unit
//
// Sequences each instruction through IF / ID / EXE / MEM / WB and decodes
// the strobes for the instruction SRAM, data SRAM, register file and PC.
// Every strobe is a combinational decode of the state register and the
// current inputs. The only registers are the state and the optional
// performance counters.
//
// Ports
//   clk          in   1   clock, rising-edge
//   reset        in   1   asynchronous active-high reset
//   inst_rdy     in   1   instruction SRAM returns an instruction this cycle
//   data_rdy     in   1   data SRAM access completes this cycle
//   dec_load     in   1   decoded instruction is ld.w
//   dec_store    in   1   decoded instruction is st.w
//   dec_gr_we    in   1   decoded instruction writes the regfile
//   inst_req     out  1   fetch request
//   ir_we        out  1   latch instruction register
//   data_req     out  1   data SRAM request
//   data_sram_we out  1   data SRAM write strobe
//   rf_we        out  1   regfile write enable
//   pc_we        out  1   PC update / retire pulse
//   state        out  3   IF=0 ID=1 EXE=2 MEM=3 WB=4 IDLE=7
//   cycle_cnt    out  32  cycle counter (0 unless MC_CTRL_PERF_EN)
//   retire_cnt   out  32  retired-instruction counter (0 unless MC_CTRL_PERF_EN)
//
// Configuration macro
//   MC_CTRL_PERF_EN  when defined, builds the cycle and retire counters;
//                    otherwise both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_rdy,
    input  logic        data_rdy,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_gr_we,
    output logic        inst_req,
    output logic        ir_we,
    output logic        data_req,
    output logic        data_sram_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_IDLE = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;

    // A simultaneous load and store is treated as a load.
    logic isLoad;
    logic isStore;
    logic isMem;

    assign isLoad  = dec_load;
    assign isStore = dec_store & ~dec_load;
    assign isMem   = dec_load | dec_store;

    // Next-state and strobe decode. Encodings 5 and 6 fall into the default
    // arm, which drives no strobes and returns to IDLE.
    always_comb begin
        state_d      = S_IDLE;
        inst_req     = 1'b0;
        ir_we        = 1'b0;
        data_req     = 1'b0;
        data_sram_we = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_IF;
            end
            S_IF: begin
                inst_req = 1'b1;
                ir_we    = inst_rdy;
                state_d  = inst_rdy ? S_ID : S_IF;
            end
            S_ID: begin
                state_d = S_EXE;
            end
            S_EXE: begin
                if (isMem) begin
                    state_d = S_MEM;
                end else if (dec_gr_we) begin
                    state_d = S_WB;
                end else begin
                    // Branch/jump without writeback retires here.
                    state_d = S_IF;
                    pc_we   = 1'b1;
                end
            end
            S_MEM: begin
                data_req     = 1'b1;
                data_sram_we = isStore;
                if (!data_rdy) begin
                    state_d = S_MEM;
                end else if (isLoad) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                    pc_we   = 1'b1;
                end
            end
            S_WB: begin
                rf_we   = dec_gr_we;
                pc_we   = 1'b1;
                state_d = S_IF;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycleCnt_q;
    logic [31:0] retireCnt_q;

    // Free-running counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCnt_q  <= 32'd0;
            retireCnt_q <= 32'd0;
        end else begin
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (pc_we) begin
                retireCnt_q <= retireCnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt  = cycleCnt_q;
    assign retire_cnt = retireCnt_q;
`else
    assign cycle_cnt  = 32'd0;
    assign retire_cnt = 32'd0;
`endif

endmodule
